// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction-fetch stage.
//   - FSM state encoding for two-word instruction assembly
//   - instruction word width and field slice positions
//   - widths of the IF/ID bundle fields
package fetch_pkg;

    localparam int unsigned INSTR_W = 16;

    // Field positions inside a 16-bit instruction word
    localparam int unsigned OPC_HI   = 15;
    localparam int unsigned OPC_LO   = 11;
    localparam int unsigned RS_HI    = 10;
    localparam int unsigned RS_LO    = 8;
    localparam int unsigned RD_HI    = 7;
    localparam int unsigned RD_LO    = 5;
    localparam int unsigned SHAMT_HI = 4;
    localparam int unsigned SHAMT_LO = 0;

    // IF/ID bundle field widths
    localparam int unsigned OPC_W   = OPC_HI - OPC_LO + 1;
    localparam int unsigned REG_W   = RS_HI - RS_LO + 1;
    localparam int unsigned SHAMT_W = SHAMT_HI - SHAMT_LO + 1;

    // S_WORD0: fetching a first word; S_WORD1: fetching the immediate word
    typedef enum logic {
        S_WORD0 = 1'b0,
        S_WORD1 = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// ifid_reg: IF/ID pipeline register.
//   clk, rst_n        : clock, synchronous active-low reset (clears everything)
//   bubble            : clear valid, hold all other fields (wins over load)
//   load              : capture d_* and set valid
//   neither           : hold
//   d_instr..d_next_pc: incoming bundle fields
//   q_valid..q_next_pc: registered bundle
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                bubble,
    input  logic [INSTR_W-1:0]  d_instr,
    input  logic [INSTR_W-1:0]  d_imm,
    input  logic                d_is_imm,
    input  logic [PC_WIDTH-1:0] d_pc,
    input  logic [PC_WIDTH-1:0] d_next_pc,
    output logic                q_valid,
    output logic [INSTR_W-1:0]  q_instr,
    output logic [INSTR_W-1:0]  q_imm,
    output logic                q_is_imm,
    output logic [PC_WIDTH-1:0] q_pc,
    output logic [PC_WIDTH-1:0] q_next_pc
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_valid   <= 1'b0;
            q_instr   <= '0;
            q_imm     <= '0;
            q_is_imm  <= 1'b0;
            q_pc      <= '0;
            q_next_pc <= '0;
        end else if (bubble) begin
            // Payload is left as-is; decode ignores it while valid is low.
            q_valid <= 1'b0;
        end else if (load) begin
            q_valid   <= 1'b1;
            q_instr   <= d_instr;
            q_imm     <= d_imm;
            q_is_imm  <= d_is_imm;
            q_pc      <= d_pc;
            q_next_pc <= d_next_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//   Owns the PC, addresses a combinational-read instruction memory, assembles
//   two-word (opcode + 16-bit immediate) instructions and presents a
//   registered IF/ID bundle to decode.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   stall                 : hold PC, FSM and IF/ID
//   flush                 : bubble IF/ID, drop a partial two-word fetch
//   redirect_valid/_pc    : load PC from redirect_pc (highest after reset)
//   imem_addr / imem_rdata: instruction memory address (= PC) / read word
//   ifid_*                : registered IF/ID bundle and decoded field slices
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned         PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = PC_WIDTH'(32'h0000_0020),
    parameter logic [OPC_W-1:0]    IMM_OPC_VAL  = 5'b00000,
    parameter logic [OPC_W-1:0]    IMM_OPC_MASK = 5'b11111
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                ifid_valid,
    output logic [INSTR_W-1:0]  ifid_instr,
    output logic [INSTR_W-1:0]  ifid_imm,
    output logic                ifid_is_imm,
    output logic [PC_WIDTH-1:0] ifid_pc,
    output logic [PC_WIDTH-1:0] ifid_next_pc,
    output logic [OPC_W-1:0]    ifid_opcode,
    output logic [REG_W-1:0]    ifid_rs,
    output logic [REG_W-1:0]    ifid_rd,
    output logic [SHAMT_W-1:0]  ifid_shamt
);

    fetch_state_t          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_inc;
    logic [INSTR_W-1:0]    held_instr_q;
    logic [PC_WIDTH-1:0]   held_pc_q;
    logic                  held_load;
    logic                  is_two;

    logic                  ld_load, ld_bubble, ld_is_imm;
    logic [INSTR_W-1:0]    ld_instr, ld_imm;
    logic [PC_WIDTH-1:0]   ld_pc, ld_next_pc;

    // Word addressing; the add wraps naturally at 2^PC_WIDTH.
    assign pc_inc    = pc_q + 1'b1;
    assign is_two    = (imem_rdata[OPC_HI:OPC_LO] & IMM_OPC_MASK) == IMM_OPC_VAL;
    assign imem_addr = pc_q;

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        held_load  = 1'b0;
        ld_load    = 1'b0;
        ld_bubble  = 1'b0;
        ld_instr   = imem_rdata;
        ld_imm     = '0;
        ld_is_imm  = 1'b0;
        ld_pc      = pc_q;
        ld_next_pc = pc_inc;

        if (redirect_valid) begin
            pc_d      = redirect_pc;
            state_d   = S_WORD0;
            ld_bubble = 1'b1;
        end else if (flush) begin
            // PC untouched: the instruction at the current PC is refetched.
            state_d   = S_WORD0;
            ld_bubble = 1'b1;
        end else if (!stall) begin
            pc_d = pc_inc;
            unique case (state_q)
                S_WORD0: begin
                    if (is_two) begin
                        held_load = 1'b1;
                        ld_bubble = 1'b1;
                        state_d   = S_WORD1;
                    end else begin
                        ld_load = 1'b1;
                    end
                end
                S_WORD1: begin
                    ld_load   = 1'b1;
                    ld_instr  = held_instr_q;
                    ld_imm    = imem_rdata;
                    ld_is_imm = 1'b1;
                    ld_pc     = held_pc_q;
                    state_d   = S_WORD0;
                end
                default: state_d = S_WORD0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_WORD0;
            pc_q         <= RESET_PC;
            held_instr_q <= '0;
            held_pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (held_load) begin
                held_instr_q <= imem_rdata;
                held_pc_q    <= pc_q;
            end
        end
    end

    ifid_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_ifid_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld_load),
        .bubble    (ld_bubble),
        .d_instr   (ld_instr),
        .d_imm     (ld_imm),
        .d_is_imm  (ld_is_imm),
        .d_pc      (ld_pc),
        .d_next_pc (ld_next_pc),
        .q_valid   (ifid_valid),
        .q_instr   (ifid_instr),
        .q_imm     (ifid_imm),
        .q_is_imm  (ifid_is_imm),
        .q_pc      (ifid_pc),
        .q_next_pc (ifid_next_pc)
    );

    assign ifid_opcode = ifid_instr[OPC_HI:OPC_LO];
    assign ifid_rs     = ifid_instr[RS_HI:RS_LO];
    assign ifid_rd     = ifid_instr[RD_HI:RD_LO];
    assign ifid_shamt  = ifid_instr[SHAMT_HI:SHAMT_LO];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (32-bit PC with default opcode match,
// 8-bit PC with a wider two-word opcode class) share control inputs and one
// 256-word instruction memory. An instruction-level reference model predicts
// each IF/ID bundle; directed steps plus a randomized phase follow.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, redirect_valid;
    logic [31:0] redirect_pc;

    logic [15:0] mem [256];

    logic [31:0] a0_addr, a0_pc, a0_npc;
    logic [15:0] r0_data, a0_instr, a0_imm;
    logic        a0_valid, a0_is_imm;
    logic [4:0]  a0_opc, a0_shamt;
    logic [2:0]  a0_rs, a0_rd;

    logic [7:0]  a1_addr, a1_pc, a1_npc;
    logic [15:0] r1_data, a1_instr, a1_imm;
    logic        a1_valid, a1_is_imm;
    logic [4:0]  a1_opc, a1_shamt;
    logic [2:0]  a1_rs, a1_rd;

    assign r0_data = mem[a0_addr[7:0]];
    assign r1_data = mem[a1_addr];

    always #5 clk = ~clk;

    fetch_unit u_dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(a0_addr), .imem_rdata(r0_data),
        .ifid_valid(a0_valid), .ifid_instr(a0_instr), .ifid_imm(a0_imm),
        .ifid_is_imm(a0_is_imm), .ifid_pc(a0_pc), .ifid_next_pc(a0_npc),
        .ifid_opcode(a0_opc), .ifid_rs(a0_rs), .ifid_rd(a0_rd), .ifid_shamt(a0_shamt)
    );

    fetch_unit #(
        .PC_WIDTH(8), .RESET_PC(8'h20), .IMM_OPC_VAL(5'b00000), .IMM_OPC_MASK(5'b11110)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc[7:0]),
        .imem_addr(a1_addr), .imem_rdata(r1_data),
        .ifid_valid(a1_valid), .ifid_instr(a1_instr), .ifid_imm(a1_imm),
        .ifid_is_imm(a1_is_imm), .ifid_pc(a1_pc), .ifid_next_pc(a1_npc),
        .ifid_opcode(a1_opc), .ifid_rs(a1_rs), .ifid_rd(a1_rd), .ifid_shamt(a1_shamt)
    );

    // ---------------- reference model (instruction level) ----------------
    typedef struct packed {
        logic        valid;
        logic [15:0] instr;
        logic [15:0] imm;
        logic        is_imm;
        logic [31:0] pc;
        logic [31:0] next_pc;
    } bundle_t;

    bundle_t     m_if      [2];
    logic [31:0] m_pc      [2];
    bit          m_partial [2];   // first word of a two-word instr captured
    logic [15:0] m_w0      [2];
    logic [31:0] m_w0pc    [2];
    logic [31:0] m_mask    [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    int unsigned m_opc_val [2] = '{0, 0};
    int unsigned m_opc_msk [2] = '{31, 30};

    int compared   = 0;
    int mismatched = 0;

    task automatic model_step(input int k);
        logic [15:0] w;
        logic [31:0] nxt;
        if (!rst_n) begin
            m_pc[k]      = 32'h20 & m_mask[k];
            m_partial[k] = 1'b0;
            m_if[k]      = '0;
        end else if (redirect_valid) begin
            m_pc[k]       = redirect_pc & m_mask[k];
            m_partial[k]  = 1'b0;
            m_if[k].valid = 1'b0;
        end else if (flush) begin
            m_partial[k]  = 1'b0;
            m_if[k].valid = 1'b0;
        end else if (!stall) begin
            w   = mem[m_pc[k] % 256];
            nxt = (m_pc[k] + 1) & m_mask[k];
            if (m_partial[k]) begin
                m_if[k]      = '{1'b1, m_w0[k], w, 1'b1, m_w0pc[k], nxt};
                m_partial[k] = 1'b0;
            end else if (((int'(w) / 2048) & m_opc_msk[k]) == m_opc_val[k]) begin
                m_w0[k]       = w;
                m_w0pc[k]     = m_pc[k];
                m_partial[k]  = 1'b1;
                m_if[k].valid = 1'b0;
            end else begin
                m_if[k] = '{1'b1, w, 16'h0000, 1'b0, m_pc[k], nxt};
            end
            m_pc[k] = nxt;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string tag, input int k);
        logic [31:0] addr, pc, npc;
        logic [15:0] instr, imm;
        logic        valid, is_imm;
        logic [4:0]  opc, shamt;
        logic [2:0]  rs, rd;
        string       t;
        if (k == 0) begin
            addr = a0_addr; valid = a0_valid; instr = a0_instr; imm = a0_imm;
            is_imm = a0_is_imm; pc = a0_pc; npc = a0_npc;
            opc = a0_opc; rs = a0_rs; rd = a0_rd; shamt = a0_shamt;
        end else begin
            addr = {24'h0, a1_addr}; valid = a1_valid; instr = a1_instr; imm = a1_imm;
            is_imm = a1_is_imm; pc = {24'h0, a1_pc}; npc = {24'h0, a1_npc};
            opc = a1_opc; rs = a1_rs; rd = a1_rd; shamt = a1_shamt;
        end
        t = $sformatf("%s/d%0d", tag, k);
        chk({t, "/addr"},  addr, m_pc[k]);
        chk({t, "/valid"}, {31'h0, valid}, {31'h0, m_if[k].valid});
        if (m_if[k].valid) begin
            chk({t, "/instr"},   {16'h0, instr}, {16'h0, m_if[k].instr});
            chk({t, "/imm"},     {16'h0, imm},   {16'h0, m_if[k].imm});
            chk({t, "/is_imm"},  {31'h0, is_imm}, {31'h0, m_if[k].is_imm});
            chk({t, "/pc"},      pc,  m_if[k].pc);
            chk({t, "/next_pc"}, npc, m_if[k].next_pc);
            chk({t, "/opcode"},  {27'h0, opc},   32'(m_if[k].instr) / 2048);
            chk({t, "/rs"},      {29'h0, rs},    (32'(m_if[k].instr) / 256) % 8);
            chk({t, "/rd"},      {29'h0, rd},    (32'(m_if[k].instr) / 32) % 8);
            chk({t, "/shamt"},   {27'h0, shamt}, 32'(m_if[k].instr) % 32);
        end
    endtask

    // Apply current inputs for one edge, advance the model, check both DUTs.
    task automatic cycle(input string tag);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_dut(tag, 0);
        check_dut(tag, 1);
    endtask

    initial begin
        logic [15:0] w;

        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 99) < 30) w[15:11] = 5'($urandom_range(0, 1));
            mem[i] = w;
        end
        mem[8'h20] = 16'h4A20;
        mem[8'h30] = 16'h0000; mem[8'h31] = 16'h1234;
        mem[8'h32] = 16'h5001; mem[8'h33] = 16'h5002; mem[8'h34] = 16'h5003;
        mem[8'h40] = 16'h0000; mem[8'h41] = 16'hBEEF;
        mem[8'h00] = 16'h7001;
        mem[8'h50] = 16'h5555;
        mem[8'hFF] = 16'h6123;

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        #2;

        // Reset
        cycle("rst0");
        cycle("rst1");
        rst_n = 1'b1;
        chk("rst_addr0", a0_addr, 32'h20);
        chk("rst_addr1", {24'h0, a1_addr}, 32'h20);
        chk("rst_valid", {31'h0, a0_valid}, 32'h0);
        chk("rst_fields", {a0_instr, a0_imm}, 32'h0);
        chk("rst_pcs", a0_pc | a0_npc | {31'h0, a0_is_imm}, 32'h0);

        // First single-word instruction after reset
        cycle("first");
        chk("first_valid", {31'h0, a0_valid}, 32'h1);
        chk("first_pc", a0_pc, 32'h20);
        chk("first_npc", a0_npc, 32'h21);
        chk("first_rs_rd_sh", {a0_rs, a0_rd, a0_shamt}, {21'h0, 3'd2, 3'd1, 5'd0});

        // Two-word instruction at 0x30
        redirect_valid = 1'b1; redirect_pc = 32'h30;
        cycle("redir30");
        redirect_valid = 1'b0;
        cycle("tw_word0");
        chk("tw_bubble", {31'h0, a0_valid}, 32'h0);
        cycle("tw_word1");
        chk("tw_valid", {31'h0, a0_valid}, 32'h1);
        chk("tw_is_imm", {31'h0, a0_is_imm}, 32'h1);
        chk("tw_instr_imm", {a0_instr, a0_imm}, 32'h0000_1234);
        chk("tw_pc", a0_pc, 32'h30);
        chk("tw_npc", a0_npc, 32'h32);

        // Stall for three cycles mid-stream
        cycle("pre_stall");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall_addr", a0_addr, 32'h33);
            chk("stall_pc", a0_pc, 32'h32);
        end
        stall = 1'b0;
        cycle("resume0");
        chk("resume_instr", {16'h0, a0_instr}, 32'h5002);
        cycle("resume1");
        chk("resume_pc", a0_pc, 32'h34);

        // Redirect (with stall) while waiting for the immediate word at 0x41
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cycle("redir40");
        redirect_valid = 1'b0;
        cycle("s40_word0");
        redirect_valid = 1'b1; redirect_pc = 32'h100; stall = 1'b1;
        cycle("redir_s1");
        chk("redir_addr0", a0_addr, 32'h100);
        chk("redir_addr1", {24'h0, a1_addr}, 32'h00);
        chk("redir_valid", {31'h0, a0_valid}, 32'h0);
        redirect_valid = 1'b0; stall = 1'b0;
        cycle("after_redir");
        chk("after_redir_pc", a0_pc, 32'h100);
        mem[8'h00] = 16'h0000;

        // Flush alone at 0x50
        redirect_valid = 1'b1; redirect_pc = 32'h50;
        cycle("redir50");
        redirect_valid = 1'b0; flush = 1'b1;
        cycle("flush");
        chk("flush_valid", {31'h0, a0_valid}, 32'h0);
        chk("flush_addr", a0_addr, 32'h50);
        flush = 1'b0;
        cycle("post_flush");
        chk("post_flush_pc", a0_pc, 32'h50);

        // 8-bit PC wrap, then reset in the middle of a two-word fetch
        redirect_valid = 1'b1; redirect_pc = 32'hFF;
        cycle("redirFF");
        redirect_valid = 1'b0;
        cycle("wrap");
        chk("wrap_npc1", {24'h0, a1_npc}, 32'h00);
        chk("wrap_addr1", {24'h0, a1_addr}, 32'h00);
        chk("wrap_npc0", a0_npc, 32'h100);
        cycle("mid_word0");
        rst_n = 1'b0;
        cycle("rst_mid");
        chk("rst_mid_addr1", {24'h0, a1_addr}, 32'h20);
        chk("rst_mid_valid1", {31'h0, a1_valid}, 32'h0);
        rst_n = 1'b1;

        // Randomized phase
        for (int n = 0; n < 400; n++) begin
            stall          = ($urandom_range(0, 99) < 20);
            flush          = ($urandom_range(0, 99) < 8);
            redirect_valid = ($urandom_range(0, 99) < 8);
            redirect_pc    = $urandom_range(0, 255);
            rst_n          = !($urandom_range(0, 99) < 2);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage for the 5-stage pipeline; successor to the single-word fetch block. Owns the PC and drives a combinational-read instruction memory. Assembles two-word (opcode + 16-bit immediate) instructions with a small FSM, honours stall, flush and redirect, and presents a registered IF/ID bundle with a valid bit to decode.

Parameters:
PC_WIDTH, 32, width of PC and all address ports
RESET_PC, 32'h0000_0020, PC value loaded on reset
IMM_OPC_VAL, 5'b00000, opcode pattern of two-word instructions
IMM_OPC_MASK, 5'b11111, opcode bits compared; two-word when (opcode & MASK) == VAL

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
stall  in  1  hazard unit: hold PC, FSM and IF/ID
flush  in  1  insert bubble into IF/ID, abandon partial two-word fetch
redirect_valid  in  1  load PC from redirect_pc (jump/branch/interrupt)
redirect_pc  in  PC_WIDTH  redirect target
imem_addr  out  PC_WIDTH  instruction memory address (= PC register)
imem_rdata  in  16  instruction word, combinational from imem_addr
ifid_valid  out  1  IF/ID bundle holds a real instruction
ifid_instr  out  16  first instruction word
ifid_imm  out  16  immediate word (0 for single-word)
ifid_is_imm  out  1  instruction is two-word
ifid_pc  out  PC_WIDTH  address of first word
ifid_next_pc  out  PC_WIDTH  address after the last word of the instruction
ifid_opcode  out  5  ifid_instr[15:11]
ifid_rs  out  3  ifid_instr[10:8]
ifid_rd  out  3  ifid_instr[7:5]
ifid_shamt  out  5  ifid_instr[4:0]

Behaviour:
- Clock port is clk; reset is rst_n, synchronous, active-low. All outputs registered except imem_addr (direct from PC reg).
- Reset: PC=RESET_PC, FSM=S_WORD0, ifid_valid=0, all other ifid_* = 0, held first-word reg=0.
- Priority per edge: reset > redirect_valid > flush > stall > normal.
- PC increment: PC+1 (word addressing), modulo 2^PC_WIDTH (all-ones wraps to 0).
- S_WORD0: is_two = (imem_rdata[15:11] & MASK) == VAL.
  - single-word: IF/ID <= {valid=1, instr=rdata, imm=0, is_imm=0, pc=PC, next_pc=PC+1}; PC<=PC+1; stay.
  - two-word: latch rdata and PC into held regs; PC<=PC+1; ifid_valid<=0; go S_WORD1.
- S_WORD1: IF/ID <= {valid=1, instr=held word, imm=rdata, is_imm=1, pc=held PC, next_pc=PC+1}; PC<=PC+1; go S_WORD0.
- Latency: single-word fetched at cycle N appears on ifid_* at N+1; two-word starting N appears at N+2 with one bubble between.
- stall (no redirect/flush): PC, FSM, held regs and all ifid_* unchanged.
- flush (no redirect): ifid_valid<=0, FSM<=S_WORD0, PC unchanged (refetch from current PC); other ifid_* don't-care but hold.
- redirect_valid: PC<=redirect_pc, FSM<=S_WORD0, ifid_valid<=0; overrides stall and flush same cycle; in S_WORD1 the partial instruction is discarded.
- ifid_opcode/rs/rd/shamt are always slices of registered ifid_instr.
- Back-to-back two-word instructions: S_WORD1 -> S_WORD0 with no extra bubble.

Decomposition:
- Shared package fetch_pkg: FSM state encoding (S_WORD0, S_WORD1), field positions (OPC_HI=15, OPC_LO=11, RS, RD, SHAMT slices), instruction width 16, IF/ID bundle field widths.
- One natural sub-module: ifid_reg (IF/ID pipeline register with load/hold/bubble controls); PC and FSM stay in fetch_unit.

Test Plan:
- Reset: rst_n=0 two cycles, release -> imem_addr=0x20, ifid_valid=0; next edge with rdata=0x4A20 (opcode 01001, single) -> ifid_valid=1, ifid_pc=0x20, ifid_next_pc=0x21, rs=2, rd=1, shamt=0.
- Two-word: at PC 0x30 rdata=0x0000 (opcode 00000), next 0x1234 -> cycle+1 ifid_valid=0; cycle+2 ifid_valid=1, is_imm=1, instr=0x0000, imm=0x1234, pc=0x30, next_pc=0x32.
- Stall: assert stall 3 cycles mid-stream -> imem_addr and all ifid_* frozen; release -> sequence resumes without loss or duplication.
- Redirect in S_WORD1: after first word of two-word instr at 0x40, redirect_valid=1 with redirect_pc=0x100 and stall=1 -> next cycle imem_addr=0x100, ifid_valid=0, FSM S_WORD0; no instruction from 0x40 ever emitted.
- Flush alone: flush=1 at PC 0x50 -> ifid_valid=0, imem_addr stays 0x50, instruction at 0x50 emitted the following cycle.
- Wrap and reset mid-operation: PC_WIDTH=8, PC=0xFF single-word -> ifid_next_pc=0x00, imem_addr=0x00; rst_n=0 during S_WORD1 -> PC=RESET_PC[7:0], ifid_valid=0.
